// File: rtl/exc_sched.sv
// rtl/exc_sched.sv - exception/interrupt scheduler feeding CP0, with post-issue flush window
module exc_sched #(
    parameter int FLUSH_CYCLES = 2,
    parameter int DS_ADJ       = 4
) (
    input  logic        cpu_clk_75M,
    input  logic        cpu_rst_n,
    input  logic        mem_valid_i,
    input  logic        mem_stall_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delay_i,
    input  logic [7:0]  mem_exc_i,
    input  logic [31:0] mem_daddr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    output logic [4:0]  exc_code_o,
    output logic [31:0] exc_epc_o,
    output logic [31:0] exc_badvaddr_o,
    output logic        exc_in_delay_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic        busy_o,
    output logic [15:0] exc_count_o
);

    localparam logic [4:0] EC_INT  = 5'h00;
    localparam logic [4:0] EC_ADEL = 5'h04;
    localparam logic [4:0] EC_ADES = 5'h05;
    localparam logic [4:0] EC_SYS  = 5'h08;
    localparam logic [4:0] EC_BP   = 5'h09;
    localparam logic [4:0] EC_RI   = 5'h0A;
    localparam logic [4:0] EC_OV   = 5'h0C;
    localparam logic [4:0] EC_ERET = 5'h0E;
    localparam logic [4:0] EC_NONE = 5'h1F;

    localparam int         LOAD_INT = (FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0;
    localparam logic [3:0] CNT_LOAD = LOAD_INT[3:0];

    typedef enum logic {
        S_IDLE,
        S_FLUSH
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_exc_count;

    logic        w_int_req;
    logic        w_accept;
    logic [4:0]  w_code;
    logic [31:0] w_badvaddr;
    logic        w_unused_ok;

    assign w_unused_ok = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    assign w_int_req = (|(cause_i[15:8] & status_i[15:8])) & status_i[0] & ~status_i[1];

    // Gated by reset so nothing reaches CP0 while reset is held.
    assign w_accept = cpu_rst_n & (r_state == S_IDLE) & mem_valid_i & ~mem_stall_i
                    & (w_int_req | (|mem_exc_i));

    always_comb begin
        w_code     = EC_NONE;
        w_badvaddr = 32'h0;
        if (w_int_req) begin
            w_code = EC_INT;
        end else if (mem_exc_i[0]) begin
            w_code     = EC_ADEL;
            w_badvaddr = mem_pc_i;
        end else if (mem_exc_i[1]) begin
            w_code = EC_RI;
        end else if (mem_exc_i[2]) begin
            w_code = EC_OV;
        end else if (mem_exc_i[3]) begin
            w_code = EC_SYS;
        end else if (mem_exc_i[4]) begin
            w_code = EC_BP;
        end else if (mem_exc_i[5]) begin
            w_code = EC_ERET;
        end else if (mem_exc_i[6]) begin
            w_code     = EC_ADEL;
            w_badvaddr = mem_daddr_i;
        end else if (mem_exc_i[7]) begin
            w_code     = EC_ADES;
            w_badvaddr = mem_daddr_i;
        end
    end

    assign exc_code_o     = w_accept ? w_code : EC_NONE;
    assign exc_epc_o      = w_accept ? (mem_in_delay_i ? (mem_pc_i - 32'(DS_ADJ)) : mem_pc_i) : 32'h0;
    assign exc_badvaddr_o = w_accept ? w_badvaddr : 32'h0;
    assign exc_in_delay_o = w_accept & mem_in_delay_i;
    assign flush_o        = w_accept | (r_state == S_FLUSH);
    assign stall_o        = (r_state == S_FLUSH);
    assign busy_o         = (r_state != S_IDLE);
    assign exc_count_o    = r_exc_count;

    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'h0;
            r_exc_count <= 16'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (r_exc_count != 16'hFFFF) begin
                            r_exc_count <= r_exc_count + 16'h1;
                        end
                        if (FLUSH_CYCLES > 1) begin
                            r_state <= S_FLUSH;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == 4'h0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'h1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_sched.sv
// tb/tb_exc_sched.sv - directed self-checking bench for exc_sched
module tb_exc_sched;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        valid1;
    logic        stall;
    logic [31:0] pc;
    logic        in_delay;
    logic [7:0]  exc;
    logic [31:0] daddr;
    logic [31:0] status;
    logic [31:0] cause;

    logic [4:0]  code;
    logic [31:0] epc;
    logic [31:0] badv;
    logic        in_delay_o;
    logic        flush;
    logic        stall_o;
    logic        busy;
    logic [15:0] count;

    logic [4:0]  code1;
    logic [31:0] epc1;
    logic [31:0] badv1;
    logic        in_delay_o1;
    logic        flush1;
    logic        stall_o1;
    logic        busy1;
    logic [15:0] count1;

    int checks;
    int failures;

    exc_sched #(.FLUSH_CYCLES(2), .DS_ADJ(4)) dut (
        .cpu_clk_75M    (clk),
        .cpu_rst_n      (rst_n),
        .mem_valid_i    (valid),
        .mem_stall_i    (stall),
        .mem_pc_i       (pc),
        .mem_in_delay_i (in_delay),
        .mem_exc_i      (exc),
        .mem_daddr_i    (daddr),
        .status_i       (status),
        .cause_i        (cause),
        .exc_code_o     (code),
        .exc_epc_o      (epc),
        .exc_badvaddr_o (badv),
        .exc_in_delay_o (in_delay_o),
        .flush_o        (flush),
        .stall_o        (stall_o),
        .busy_o         (busy),
        .exc_count_o    (count)
    );

    exc_sched #(.FLUSH_CYCLES(1), .DS_ADJ(4)) dut1 (
        .cpu_clk_75M    (clk),
        .cpu_rst_n      (rst_n),
        .mem_valid_i    (valid1),
        .mem_stall_i    (stall),
        .mem_pc_i       (pc),
        .mem_in_delay_i (in_delay),
        .mem_exc_i      (exc),
        .mem_daddr_i    (daddr),
        .status_i       (status),
        .cause_i        (cause),
        .exc_code_o     (code1),
        .exc_epc_o      (epc1),
        .exc_badvaddr_o (badv1),
        .exc_in_delay_o (in_delay_o1),
        .flush_o        (flush1),
        .stall_o        (stall_o1),
        .busy_o         (busy1),
        .exc_count_o    (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        next_cycle();
        valid    = 1'b0;
        exc      = 8'h00;
        in_delay = 1'b0;
        stall    = 1'b0;
        status   = 32'h0;
        cause    = 32'h0;
        repeat (2) next_cycle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        valid    = 1'b1;
        valid1   = 1'b0;
        stall    = 1'b0;
        pc       = 32'hBFC0_0000;
        in_delay = 1'b0;
        exc      = 8'h02;
        daddr    = 32'h0;
        status   = 32'h0;
        cause    = 32'h0;

        // Reset held with a pending exception on the inputs
        @(negedge clk);
        check("rst_code", 32'(code), 32'h1F);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_epc", epc, 32'h0);
        valid = 1'b0;
        exc   = 8'h00;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // 1: RI issue and one-cycle flush window
        pc = 32'hBFC0_0100; exc = 8'h02; valid = 1'b1;
        @(negedge clk);
        check("t1_code", 32'(code), 32'h0A);
        check("t1_epc", epc, 32'hBFC0_0100);
        check("t1_flush", 32'(flush), 32'h1);
        check("t1_stall_issue", 32'(stall_o), 32'h0);
        check("t1_badv", badv, 32'h0);
        next_cycle();
        valid = 1'b0; exc = 8'h00;
        @(negedge clk);
        check("t1_fl_flush", 32'(flush), 32'h1);
        check("t1_fl_stall", 32'(stall_o), 32'h1);
        check("t1_fl_busy", 32'(busy), 32'h1);
        check("t1_fl_code", 32'(code), 32'h1F);
        check("t1_count", 32'(count), 32'h1);
        next_cycle();
        @(negedge clk);
        check("t1_idle_busy", 32'(busy), 32'h0);
        check("t1_idle_flush", 32'(flush), 32'h0);

        // 2: ov+sys+ades_d in delay slot
        next_cycle();
        pc = 32'h8000_0008; in_delay = 1'b1; exc = 8'h8C; daddr = 32'h1234_5678; valid = 1'b1;
        @(negedge clk);
        check("t2_code", 32'(code), 32'h0C);
        check("t2_epc", epc, 32'h8000_0004);
        check("t2_in_delay", 32'(in_delay_o), 32'h1);
        check("t2_badv", badv, 32'h0);
        settle();

        // 3: interrupt, then masked by EXL
        pc = 32'h8000_0100; status = 32'h0000_0401; cause = 32'h0000_0400; valid = 1'b1;
        @(negedge clk);
        check("t3_int_code", 32'(code), 32'h00);
        check("t3_int_epc", epc, 32'h8000_0100);
        settle();
        status = 32'h0000_0403; cause = 32'h0000_0400; valid = 1'b1;
        @(negedge clk);
        check("t3_exl_code", 32'(code), 32'h1F);
        check("t3_exl_flush", 32'(flush), 32'h0);
        settle();

        // Int beats eret; eret alone with EXL=1; adel_f reports PC
        status = 32'h0000_0401; cause = 32'h0000_0400; exc = 8'h20; valid = 1'b1;
        @(negedge clk);
        check("int_eret_code", 32'(code), 32'h00);
        settle();
        status = 32'h0000_0003; exc = 8'h20; valid = 1'b1;
        @(negedge clk);
        check("eret_code", 32'(code), 32'h0E);
        settle();
        pc = 32'hBFC0_0201; exc = 8'h01; daddr = 32'hDEAD_BEEF; valid = 1'b1;
        @(negedge clk);
        check("adelf_code", 32'(code), 32'h04);
        check("adelf_badv", badv, 32'hBFC0_0201);
        settle();

        // 4: adel_d held off by stall
        pc = 32'h8000_0040; exc = 8'h40; daddr = 32'h8000_0003; valid = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_stall_code", 32'(code), 32'h1F);
            check("t4_stall_flush", 32'(flush), 32'h0);
            next_cycle();
        end
        stall = 1'b0;
        @(negedge clk);
        check("t4_code", 32'(code), 32'h04);
        check("t4_badv", badv, 32'h8000_0003);
        check("t4_epc", epc, 32'h8000_0040);
        settle();

        // 5: RI during FLUSH ignored, reissued in IDLE, reset mid-FLUSH
        rst_n = 1'b0;
        #1;
        check("t5_pre_count", 32'(count), 32'h0);
        next_cycle();
        rst_n = 1'b1;
        pc = 32'h8000_0200; exc = 8'h02; valid = 1'b1;
        @(negedge clk);
        check("t5_first_code", 32'(code), 32'h0A);
        next_cycle();
        @(negedge clk);
        check("t5_fl_code", 32'(code), 32'h1F);
        check("t5_fl_stall", 32'(stall_o), 32'h1);
        next_cycle();
        @(negedge clk);
        check("t5_second_code", 32'(code), 32'h0A);
        next_cycle();
        @(negedge clk);
        check("t5_count", 32'(count), 32'h2);
        check("t5_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_flush", 32'(flush), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_count", 32'(count), 32'h0);
        valid = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // 6: count saturation on the FLUSH_CYCLES=1 instance
        exc = 8'h02; valid1 = 1'b1;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check("t6_fc1_busy", 32'(busy1), 32'h0);
        check("t6_fc1_flush", 32'(flush1), 32'h1);
        check("t6_count_fffe", 32'(count1), 32'h0000_FFFE);
        @(posedge clk);
        @(negedge clk);
        check("t6_count_ffff", 32'(count1), 32'h0000_FFFF);
        @(posedge clk);
        @(negedge clk);
        check("t6_count_sat", 32'(count1), 32'h0000_FFFF);
        check("t6_main_idle", 32'(count), 32'h0);
        valid1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
